// File: rtl/decompress_pkg.sv
// Shared types and widths for the decompression fetcher.
package decompress_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int BYTE_IDX_W = 32;
    localparam int BIT_IDX_W  = 3;
    localparam int RUN_LEN_W  = 7;
    localparam int PAIR_CNT_W = 16;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RD1   = 4'd1,
        CAP1  = 4'd2,
        RD2   = 4'd3,
        CAP2  = 4'd4,
        ISSUE = 4'd5,
        WAIT  = 4'd6,
        NEXT  = 4'd7,
        FIN   = 4'd8
    } fetch_state_e;

    // Each pair occupies two bytes; the address wraps at the top of RAM.
    function automatic logic [ADDR_W-1:0] pair_addr(
        input logic [ADDR_W-1:0]     base,
        input logic [PAIR_CNT_W-1:0] idx
    );
        return base + {idx[ADDR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/decompress_fetcher.sv
// Fetches compressed {run, value} byte pairs from RAM and hands each to a decompress handler.
// Optional build macro DECOMP_FETCH_ZERO_SKIP_EN: zero-length pairs bypass the handler.
module decompress_fetcher
    import decompress_pkg::*;
(
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     srcBase,
    input  logic [PAIR_CNT_W-1:0] pairCount,
    input  logic [BYTE_IDX_W-1:0] dstByteIndx,
    input  logic [BIT_IDX_W-1:0]  dstBitIndx,
    output logic [ADDR_W-1:0]     ramAddress,
    output logic                  ramReadSignal,
    input  logic [DATA_W-1:0]     ramDataIn,
    output logic [DATA_W-1:0]     in1,
    output logic [DATA_W-1:0]     in2,
    output logic [BYTE_IDX_W-1:0] byteIndx,
    output logic [BIT_IDX_W-1:0]  bitIndx,
    output logic                  work,
    output logic                  working,
    input  logic                  handlerDone,
    input  logic [BYTE_IDX_W-1:0] newByteIndx,
    input  logic [BIT_IDX_W-1:0]  newBitIndx,
    output logic                  busy,
    output logic                  finished,
    output logic [PAIR_CNT_W-1:0] pairsIssued
);

    fetch_state_e          r_state;
    fetch_state_e          w_next_state;
    logic [ADDR_W-1:0]     r_src;
    logic [PAIR_CNT_W-1:0] r_count;
    logic [PAIR_CNT_W-1:0] r_pairs;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_rd;
    logic [DATA_W-1:0]     r_in1;
    logic [DATA_W-1:0]     r_in2;
    logic [BYTE_IDX_W-1:0] r_byte;
    logic [BIT_IDX_W-1:0]  r_bit;
    logic                  r_work;
    logic                  r_busy;
    logic                  r_fin;
    logic                  w_skip;
    logic                  w_done;

`ifdef DECOMP_FETCH_ZERO_SKIP_EN
    assign w_skip = (r_in1[RUN_LEN_W-1:0] == {RUN_LEN_W{1'b0}});
`else
    assign w_skip = 1'b0;
`endif

    // handlerDone only counts while a pair is actually outstanding
    assign w_done = (r_state == WAIT) && handlerDone;

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (pairCount == {PAIR_CNT_W{1'b0}}) begin
                        w_next_state = FIN;
                    end else begin
                        w_next_state = RD1;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            RD1:   w_next_state = CAP1;
            CAP1:  w_next_state = RD2;
            RD2:   w_next_state = CAP2;
            CAP2: begin
                if (w_skip) begin
                    w_next_state = NEXT;
                end else begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: w_next_state = WAIT;
            WAIT: begin
                if (handlerDone) begin
                    w_next_state = NEXT;
                end else begin
                    w_next_state = WAIT;
                end
            end
            NEXT: begin
                if (r_pairs == r_count) begin
                    w_next_state = FIN;
                end else begin
                    w_next_state = RD1;
                end
            end
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs, all decoded from the upcoming state
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_src   <= {ADDR_W{1'b0}};
            r_count <= {PAIR_CNT_W{1'b0}};
            r_pairs <= {PAIR_CNT_W{1'b0}};
            r_addr  <= {ADDR_W{1'b0}};
            r_rd    <= 1'b0;
            r_in1   <= {DATA_W{1'b0}};
            r_in2   <= {DATA_W{1'b0}};
            r_byte  <= {BYTE_IDX_W{1'b0}};
            r_bit   <= 3'd7;
            r_work  <= 1'b0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_rd   <= (w_next_state == RD1) || (w_next_state == RD2);
            r_work <= (w_next_state == ISSUE) || (w_next_state == WAIT);
            r_busy <= (w_next_state != IDLE);
            r_fin  <= (r_state == FIN);

            // Leaving IDLE the latched base is not yet visible, so use the port
            if (w_next_state == RD1) begin
                if (r_state == IDLE) begin
                    r_addr <= srcBase;
                end else begin
                    r_addr <= pair_addr(r_src, r_pairs);
                end
            end else if (w_next_state == RD2) begin
                r_addr <= r_addr + 16'd1;
            end

            if ((r_state == IDLE) && start) begin
                r_src   <= srcBase;
                r_count <= pairCount;
                r_byte  <= dstByteIndx;
                r_bit   <= dstBitIndx;
                r_pairs <= {PAIR_CNT_W{1'b0}};
            end else if (w_done || ((r_state == CAP2) && w_skip)) begin
                r_pairs <= r_pairs + 16'd1;
            end

            if (w_done) begin
                r_byte <= newByteIndx;
                r_bit  <= newBitIndx;
            end

            if (r_state == CAP1) begin
                r_in1 <= ramDataIn;
            end
            if (r_state == CAP2) begin
                r_in2 <= ramDataIn;
            end
        end
    end

    assign ramAddress    = r_addr;
    assign ramReadSignal = r_rd;
    assign in1           = r_in1;
    assign in2           = r_in2;
    assign byteIndx      = r_byte;
    assign bitIndx       = r_bit;
    assign work          = r_work;
    assign working       = r_work;
    assign busy          = r_busy;
    assign finished      = r_fin;
    assign pairsIssued   = r_pairs;

endmodule

// File: tb/tb_decompress_fetcher.sv
// Scoreboard bench for decompress_fetcher: RAM model, handler model, queued expectations.
`timescale 1ns/1ps
module tb_decompress_fetcher;
    import decompress_pkg::*;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start;
    logic [15:0] srcBase;
    logic [15:0] pairCount;
    logic [31:0] dstByteIndx;
    logic [2:0]  dstBitIndx;
    logic [15:0] ramAddress;
    logic        ramReadSignal;
    logic [7:0]  ramDataIn = 8'h00;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [31:0] byteIndx;
    logic [2:0]  bitIndx;
    logic        work;
    logic        working;
    logic        handlerDone;
    logic [31:0] newByteIndx;
    logic [2:0]  newBitIndx;
    logic        busy;
    logic        finished;
    logic [15:0] pairsIssued;

    decompress_fetcher dut (
        .clk(clk), .RST(RST), .start(start), .srcBase(srcBase), .pairCount(pairCount),
        .dstByteIndx(dstByteIndx), .dstBitIndx(dstBitIndx), .ramAddress(ramAddress),
        .ramReadSignal(ramReadSignal), .ramDataIn(ramDataIn), .in1(in1), .in2(in2),
        .byteIndx(byteIndx), .bitIndx(bitIndx), .work(work), .working(working),
        .handlerDone(handlerDone), .newByteIndx(newByteIndx), .newBitIndx(newBitIndx),
        .busy(busy), .finished(finished), .pairsIssued(pairsIssued)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  in1;
        logic [7:0]  in2;
        logic [31:0] bi;
        logic [2:0]  bt;
    } iss_t;

    typedef struct packed {
        logic [31:0] bi;
        logic [2:0]  bt;
        logic [15:0] pairs;
    } fin_t;

    logic [15:0] rd_q[$];
    iss_t        iss_q[$];
    fin_t        fin_q[$];

    int errors = 0;
    int checks = 0;
    int work_rises = 0;
    int h_lat = 3;
    logic spur_req = 1'b0;
    logic [7:0] mem [0:65535];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_iss(input logic [7:0] a, input logic [7:0] b, input logic [31:0] bi, input logic [2:0] bt);
        iss_t e;
        e.in1 = a; e.in2 = b; e.bi = bi; e.bt = bt;
        iss_q.push_back(e);
    endtask

    task automatic push_fin(input logic [31:0] bi, input logic [2:0] bt, input logic [15:0] p);
        fin_t e;
        e.bi = bi; e.bt = bt; e.pairs = p;
        fin_q.push_back(e);
    endtask

    // Called at a falling edge; returns one falling edge later with start dropped
    task automatic start_run(input logic [15:0] b, input logic [15:0] n, input logic [31:0] bi, input logic [2:0] bt);
        start = 1'b1; srcBase = b; pairCount = n; dstByteIndx = bi; dstBitIndx = bt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fin(input string name, input int bound);
        int n;
        n = 0;
        while (!finished && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, finished, 1'b1);
    endtask

    task automatic wait_working(input string name, input int bound);
        int n;
        n = 0;
        while (!working && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, working, 1'b1);
    endtask

    // RAM: data is presented the cycle after the read strobe
    always @(posedge clk) begin
        if (ramReadSignal) ramDataIn <= mem[ramAddress];
    end

    // Handler: advances the bit position by the run length after h_lat cycles
    initial begin : handler
        int cnt;
        logic [34:0] hp;
        cnt = 0;
        handlerDone = 1'b0; newByteIndx = 32'h0; newBitIndx = 3'd0;
        forever begin
            @(negedge clk);
            handlerDone = 1'b0;
            if (spur_req) begin
                handlerDone = 1'b1;
                newByteIndx = 32'hDEAD_BEEF;
                newBitIndx  = 3'd0;
                spur_req    = 1'b0;
            end else if (working) begin
                if (cnt >= h_lat) begin
                    hp = {byteIndx, 3'b000} + 35'(3'd7 - bitIndx) + 35'(in1[6:0]);
                    newByteIndx = hp[34:3];
                    newBitIndx  = 3'd7 - hp[2:0];
                    handlerDone = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the expected response whenever the DUT presents one
    initial begin : monitor
        logic prev_work;
        logic [7:0] cur_in1, cur_in2;
        logic [15:0] ea;
        iss_t ei;
        fin_t ef;
        prev_work = 1'b0; cur_in1 = 8'h0; cur_in2 = 8'h0;
        forever begin
            @(negedge clk);
            if (ramReadSignal) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: read at %0h, none expected", ramAddress);
                end else begin
                    ea = rd_q.pop_front();
                    check("rd_addr", ramAddress, ea);
                end
            end
            if (work && !prev_work) begin
                work_rises++;
                cur_in1 = in1; cur_in2 = in2;
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL iss_unexpected: in1=%0h in2=%0h", in1, in2);
                end else begin
                    ei = iss_q.pop_front();
                    check("iss_in1", in1, ei.in1);
                    check("iss_in2", in2, ei.in2);
                    check("iss_byte", byteIndx, ei.bi);
                    check("iss_bit", bitIndx, ei.bt);
                    check("iss_working", working, 1'b1);
                end
            end else if (working) begin
                check("in1_stable", in1, cur_in1);
                check("in2_stable", in2, cur_in2);
            end
            prev_work = work;
            if (finished) begin
                if (fin_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fin_unexpected: byte=%0h bit=%0h", byteIndx, bitIndx);
                end else begin
                    ef = fin_q.pop_front();
                    check("fin_byte", byteIndx, ef.bi);
                    check("fin_bit", bitIndx, ef.bt);
                    check("fin_pairs", pairsIssued, ef.pairs);
                    check("fin_busy", busy, 1'b0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, ramAddress, 16'h0);
        check({tag, "_rd"}, ramReadSignal, 1'b0);
        check({tag, "_in"}, {in1, in2}, 16'h0);
        check({tag, "_byte"}, byteIndx, 32'h0);
        check({tag, "_bit"}, bitIndx, 3'd7);
        check({tag, "_work"}, {work, working}, 2'b00);
        check({tag, "_busyfin"}, {busy, finished}, 2'b00);
        check({tag, "_pairs"}, pairsIssued, 16'h0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int exp_rises;
        start = 1'b0; srcBase = 16'h0; pairCount = 16'h0; dstByteIndx = 32'h0; dstBitIndx = 3'd0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h85; mem[16'h0101] = 8'h3C;
        mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
        mem[16'h0200] = 8'h81; mem[16'h0201] = 8'h11;
        mem[16'h0202] = 8'h02; mem[16'h0203] = 8'h22;
        mem[16'h0204] = 8'h83; mem[16'h0205] = 8'h33;
        mem[16'h0300] = 8'h80; mem[16'h0301] = 8'h55;
        mem[16'h0302] = 8'h03; mem[16'h0303] = 8'h66;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        RST = 1'b0;

        // Basic single pair
        h_lat = 4;
        rd_q.push_back(16'h0100); rd_q.push_back(16'h0101);
        push_iss(8'h85, 8'h3C, 32'h10, 3'd7);
        push_fin(32'h10, 3'd2, 16'd1);
        start_run(16'h0100, 16'd1, 32'h10, 3'd7);
        check("t1_busy", busy, 1'b1);
        wait_fin("t1_finished", 100);
        @(negedge clk);
        check("t1_fin_one_cycle", finished, 1'b0);

        // Zero pairs, then a start in the very cycle finished is shown
        push_fin(32'h77, 3'd3, 16'd0);
        start_run(16'h0100, 16'd0, 32'h77, 3'd3);
        check("t2_fin_early", finished, 1'b0);
        check("t2_busy", busy, 1'b1);
        @(negedge clk);
        check("t2_fin_at_2", finished, 1'b1);
        push_fin(32'h78, 3'd5, 16'd0);
        start_run(16'h0100, 16'd0, 32'h78, 3'd5);
        check("t2b_accepted", busy, 1'b1);
        @(negedge clk);
        check("t2b_fin_at_2", finished, 1'b1);
        @(negedge clk);

        // Address wrap
        rd_q.push_back(16'hFFFF); rd_q.push_back(16'h0000);
        push_iss(8'h12, 8'h34, 32'h0, 3'd7);
        push_fin(32'h2, 3'd5, 16'd1);
        start_run(16'hFFFF, 16'd1, 32'h0, 3'd7);
        wait_fin("t3_finished", 100);
        @(negedge clk);

        // Reset during the second handler wait
        h_lat = 20;
        for (int a = 16'h0200; a < 16'h0204; a++) rd_q.push_back(16'(a));
        push_iss(8'h81, 8'h11, 32'h40, 3'd7);
        push_iss(8'h02, 8'h22, 32'h40, 3'd6);
        start_run(16'h0200, 16'd3, 32'h40, 3'd7);
        begin
            int n;
            n = 0;
            while (!(working && pairsIssued == 16'd1) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("t4_second_wait", {working, pairsIssued}, {1'b1, 16'd1});
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 RST = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        RST = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_no_fin", finished, 1'b0);

        // Clean rerun of three pairs
        h_lat = 3;
        for (int a = 16'h0200; a < 16'h0206; a++) rd_q.push_back(16'(a));
        push_iss(8'h81, 8'h11, 32'h40, 3'd7);
        push_iss(8'h02, 8'h22, 32'h40, 3'd6);
        push_iss(8'h83, 8'h33, 32'h40, 3'd4);
        push_fin(32'h40, 3'd1, 16'd3);
        start_run(16'h0200, 16'd3, 32'h40, 3'd7);
        wait_fin("t5_finished", 300);
        @(negedge clk);

        // Zero-length pair handling
        work_rises = 0;
        for (int a = 16'h0300; a < 16'h0304; a++) rd_q.push_back(16'(a));
`ifdef DECOMP_FETCH_ZERO_SKIP_EN
        exp_rises = 1;
`else
        exp_rises = 2;
        push_iss(8'h80, 8'h55, 32'h1, 3'd7);
`endif
        push_iss(8'h03, 8'h66, 32'h1, 3'd7);
        push_fin(32'h1, 3'd4, 16'd2);
        start_run(16'h0300, 16'd2, 32'h1, 3'd7);
        wait_fin("t6_finished", 200);
        check("t6_work_rises", work_rises, exp_rises);
        @(negedge clk);

        // Stray handlerDone in IDLE
        @(posedge clk);
        #1 spur_req = 1'b1;
        repeat (2) @(negedge clk);
        check("t7_idle_pos", {byteIndx, bitIndx}, {32'h1, 3'd4});
        check("t7_idle_state", {busy, pairsIssued}, {1'b0, 16'd2});

        // Stray handlerDone in RD1 and start during WAIT
        h_lat = 4;
        rd_q.push_back(16'h0100); rd_q.push_back(16'h0101);
        push_iss(8'h85, 8'h3C, 32'h20, 3'd7);
        push_fin(32'h20, 3'd2, 16'd1);
        start = 1'b1; srcBase = 16'h0100; pairCount = 16'd1; dstByteIndx = 32'h20; dstBitIndx = 3'd7;
        @(posedge clk);
        #1 spur_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t8_rd1_pos", {byteIndx, bitIndx, pairsIssued}, {32'h20, 3'd7, 16'd0});
        wait_working("t8_working", 50);
        @(negedge clk);
        start = 1'b1; srcBase = 16'h0300; pairCount = 16'd5; dstByteIndx = 32'h99; dstBitIndx = 3'd0;
        @(negedge clk);
        start = 1'b0;
        wait_fin("t8_finished", 100);
        repeat (3) @(negedge clk);

        check("rd_q_drained", rd_q.size(), 0);
        check("iss_q_drained", iss_q.size(), 0);
        check("fin_q_drained", fin_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decompress_fetcher.md
DECOMPRESS_FETCHER -- requirements
Module: decompress_fetcher

Interface
REQ-001 Port clk  input  1  rising-edge clock for all state.
REQ-002 Port RST  input  1  asynchronous active-high reset.
REQ-003 Port start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-004 Port srcBase  input  16  RAM address of first compressed byte.
REQ-005 Port pairCount  input  16  number of compressed pairs (2 bytes each) to process.
REQ-006 Port dstByteIndx / dstBitIndx  input  32 / 3  initial output write position; bit 7 = MSB, next bit to fill.
REQ-007 Port ramAddress  output  16  RAM read address.
REQ-008 Port ramReadSignal  output  1  RAM read strobe; data valid on ramDataIn the following cycle.
REQ-009 Port ramDataIn  input  8  RAM read data.
REQ-010 Port in1 / in2  output  8 / 8  compressed pair to decompress handler; in1 = {bitValue, runLength[6:0]}.
REQ-011 Port byteIndx / bitIndx  output  32 / 3  current write position presented to handler.
REQ-012 Port work / working  output  1 / 1  handler enable and in-progress qualifiers.
REQ-013 Port handlerDone  input  1  handler completion pulse for current pair.
REQ-014 Port newByteIndx / newBitIndx  input  32 / 3  updated write position from handler, valid with handlerDone.
REQ-015 Port busy  output  1  high from accepted start until finished.
REQ-016 Port finished  output  1  one-cycle pulse at end of run.
REQ-017 Port pairsIssued  output  16  count of pairs handed to handler in current run.

Function
REQ-018 FSM states SHALL be IDLE, RD1, CAP1, RD2, CAP2, ISSUE, WAIT, NEXT, FIN.
REQ-019 IDLE + start: latch srcBase, pairCount, dstByteIndx, dstBitIndx; clear pairsIssued; busy=1; go RD1, or FIN if pairCount==0 (no RAM access).
REQ-020 RD1: ramAddress=srcBase+2*pairsIssued (mod 2^16), ramReadSignal=1; next CAP1.
REQ-021 CAP1: ramReadSignal=0, capture ramDataIn into in1; next RD2.
REQ-022 RD2/CAP2: same as RD1/CAP1 at address+1 (mod 2^16), capturing in2.
REQ-023 ISSUE: work=1, working=1 for this and all WAIT cycles; next WAIT.
REQ-024 WAIT: on handlerDone=1 capture newByteIndx/newBitIndx into byteIndx/bitIndx, drop work/working, increment pairsIssued; go NEXT. handlerDone outside WAIT SHALL be ignored.
REQ-025 NEXT: if pairsIssued==pairCount go FIN, else RD1.
REQ-026 FIN: finished=1 for exactly one cycle, busy=0, return IDLE; byteIndx/bitIndx hold final position.
REQ-027 start while busy SHALL be ignored; a new start in the cycle after FIN is accepted.
REQ-028 in1/in2 SHALL remain stable from CAP2 until handlerDone.
REQ-029 Latency per non-skipped pair = 6 cycles + handler cycles (RD1..ISSUE, NEXT).

Reset
REQ-030 RST asserted (any time, including mid-run) SHALL immediately force IDLE and all outputs to zero, except bitIndx=7; no finished pulse is generated.

Configuration
REQ-031 Macro DECOMP_FETCH_ZERO_SKIP_EN defined: pair with in1[6:0]==0 SHALL bypass ISSUE/WAIT (CAP2 -> NEXT), increment pairsIssued, leave position unchanged.
REQ-032 Macro undefined: zero-length pairs SHALL be issued to the handler like any other.

Structure
REQ-033 Shared package decompress_pkg SHALL hold FSM state encoding, ADDR_W=16, DATA_W=8, BYTE_IDX_W=32, BIT_IDX_W=3, RUN_LEN_W=7.
REQ-034 Single module; no sub-module; address generator inline.

Verification
REQ-035 srcBase=0x0100, pairCount=1, RAM[0x100]=0x85, RAM[0x101]=0x3C, handler done after 4 cycles with newByteIndx=0x10, newBitIndx=2 -> in1=0x85, in2=0x3C, byteIndx=0x10, bitIndx=2, one finished pulse, pairsIssued=1.
REQ-036 pairCount=0 -> no ramReadSignal, finished pulse two cycles after start.
REQ-037 srcBase=0xFFFF, pairCount=1 -> reads at 0xFFFF then 0x0000.
REQ-038 pairCount=3, RST asserted during second WAIT -> all outputs zero/bitIndx=7 same cycle, no finished, next start runs cleanly.
REQ-039 With DECOMP_FETCH_ZERO_SKIP_EN, pairs {0x80,..},{0x03,..} -> work raised only once, pairsIssued=2.
REQ-040 handlerDone pulsed in IDLE and RD1, start pulsed during WAIT -> no state change, no position update.
